// File: rtl/bsg_counter_pkg.sv
// Shared types for the bsg counter family.
package bsg_counter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/bsg_counter_set_down.sv
// Loadable down-counter with IDLE/RUN tracking, a done pulse on countdown
// completion and an underflow pulse when a decrement is requested at zero.
module bsg_counter_set_down
    import bsg_counter_pkg::*;
#(
    parameter int unsigned          width_p    = 64,
    parameter logic [width_p-1:0]   init_val_p = '0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               set_i,
    input  logic [width_p-1:0] val_i,
    input  logic               down_i,
    output logic [width_p-1:0] count_o,
    output logic               zero_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               underflow_o
);

    localparam state_e reset_state_lp = (init_val_p != '0) ? RUN : IDLE;
    localparam logic [width_p-1:0] one_lp = width_p'(1);

    logic [width_p-1:0] count_q, count_d;
    state_e             state_q, state_d;
    logic               done_q, done_d;
    logic               underflow_q, underflow_d;

    // Load takes priority; a decrement is never applied at zero.
    always_comb begin
        count_d     = count_q;
        state_d     = state_q;
        done_d      = 1'b0;
        underflow_d = 1'b0;
        if (set_i) begin
            count_d = val_i;
            state_d = (val_i != '0) ? RUN : IDLE;
        end else if (down_i) begin
            if (count_q == '0) begin
                underflow_d = 1'b1;
            end else begin
                count_d = count_q - one_lp;
                if (count_q == one_lp) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q     <= init_val_p;
            state_q     <= reset_state_lp;
            done_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            state_q     <= state_d;
            done_q      <= done_d;
            underflow_q <= underflow_d;
        end
    end

    assign count_o     = count_q;
    assign zero_o      = (count_q == '0);
    assign busy_o      = (state_q == RUN);
    assign done_o      = done_q;
    assign underflow_o = underflow_q;

endmodule

// File: tb/tb_bsg_counter_set_down.sv
// Self-checking bench for bsg_counter_set_down: directed vector table,
// asynchronous reset sequence and randomized run against a reference model.
module tb_bsg_counter_set_down;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_i = 1'b1;
    logic         set_i = 1'b0;
    logic [W-1:0] val_i = '0;
    logic         down_i = 1'b0;
    logic [W-1:0] count_o;
    logic         zero_o, busy_o, done_o, underflow_o;

    int n_cmp = 0;
    int n_bad = 0;

    bsg_counter_set_down #(.width_p(W), .init_val_p('0)) dut (
        .clk_i(clk), .reset_i(reset_i), .set_i(set_i), .val_i(val_i),
        .down_i(down_i), .count_o(count_o), .zero_o(zero_o), .busy_o(busy_o),
        .done_o(done_o), .underflow_o(underflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         set;
        logic [W-1:0] val;
        logic         down;
        int           e_count;
        logic         e_zero, e_busy, e_done, e_uf;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int c, input logic z, input logic b,
                           input logic d, input logic u);
        chk({tag, ".count"}, int'(count_o), c);
        chk({tag, ".zero"}, int'(zero_o), int'(z));
        chk({tag, ".busy"}, int'(busy_o), int'(b));
        chk({tag, ".done"}, int'(done_o), int'(d));
        chk({tag, ".underflow"}, int'(underflow_o), int'(u));
    endtask

    // Drive inputs, advance one rising edge, land 1 time unit after it.
    task automatic step(input logic s, input logic [W-1:0] v, input logic dn);
        set_i = s; val_i = v; down_i = dn;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];
    int   mdl_count;
    logic mdl_done, mdl_uf;

    initial begin
        // row: set val down -> count zero busy done underflow
        vecs.push_back('{1'b1, 8'd3,   1'b0, 3,   1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'd0,   1'b1, 2,   1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'd0,   1'b1, 1,   1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'd0,   1'b1, 0,   1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'd0,   1'b0, 0,   1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'd0,   1'b1, 0,   1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 8'd0,   1'b0, 0,   1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'd5,   1'b1, 5,   1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'd0,   1'b0, 5,   1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'd7,   1'b0, 7,   1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'd0,   1'b0, 0,   1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'd0,   1'b1, 0,   1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'd255, 1'b0, 255, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'd0,   1'b1, 254, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'd1,   1'b0, 1,   1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'd0,   1'b1, 0,   1'b1, 1'b0, 1'b1, 1'b0});

        // Reset state, visible before any clock edge.
        #1;
        chk_all("reset", 0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_i = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            step(vecs[i].set, vecs[i].val, vecs[i].down);
            $display("vec %0d: set=%0b val=%0d down=%0b -> count=%0d done=%0b uf=%0b",
                     i, vecs[i].set, vecs[i].val, vecs[i].down, count_o, done_o, underflow_o);
            chk_all($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_zero,
                    vecs[i].e_busy, vecs[i].e_done, vecs[i].e_uf);
        end

        // Full countdown from the maximum value ends in a single done pulse.
        step(1'b1, 8'd255, 1'b0);
        for (int k = 254; k >= 0; k--) begin
            step(1'b0, 8'd0, 1'b1);
            if (k == 200 || k <= 1) chk($sformatf("maxdown.count%0d", k), int'(count_o), k);
        end
        chk("maxdown.done", int'(done_o), 1);
        chk("maxdown.busy", int'(busy_o), 0);
        step(1'b0, 8'd0, 1'b0);
        chk("maxdown.done_clear", int'(done_o), 0);
        $display("seq maxdown: count=%0d", count_o);

        // Asynchronous reset mid-countdown at count 2.
        step(1'b1, 8'd3, 1'b0);
        step(1'b0, 8'd0, 1'b1);
        chk("arst.pre_count", int'(count_o), 2);
        #2;
        reset_i = 1'b1;
        #1;
        chk_all("arst.immediate", 0, 1'b1, 1'b0, 1'b0, 1'b0);
        set_i = 1'b1; val_i = 8'd9; down_i = 1'b1;
        @(posedge clk);
        #1;
        chk_all("arst.held", 0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_i = 1'b0;
        step(1'b0, 8'd0, 1'b0);
        chk_all("arst.after", 0, 1'b1, 1'b0, 1'b0, 1'b0);
        $display("seq arst: count=%0d done=%0b", count_o, done_o);

        // Randomized run against a reference model.
        mdl_count = 0;
        for (int t = 0; t < 3000; t++) begin
            logic         s, dn;
            logic [W-1:0] v;
            s  = ($urandom_range(0, 7) == 0);
            dn = ($urandom_range(0, 3) != 0);
            v  = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 4));
            mdl_done = !s && dn && (mdl_count == 1);
            mdl_uf   = !s && dn && (mdl_count == 0);
            if (s)                         mdl_count = int'(v);
            else if (dn && mdl_count > 0)  mdl_count = mdl_count - 1;
            step(s, v, dn);
            chk_all($sformatf("rnd%0d", t), mdl_count, mdl_count == 0, mdl_count != 0,
                    mdl_done, mdl_uf);
            if ($urandom_range(0, 199) == 0) begin
                #2;
                reset_i = 1'b1;
                #1;
                mdl_count = 0;
                chk_all($sformatf("rnd%0d.rst", t), 0, 1'b1, 1'b0, 1'b0, 1'b0);
                #1;
                reset_i = 1'b0;
            end
        end
        $display("random phase done: %0d compared so far", n_cmp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
